// File: rtl/fabric_reset_sequencer_if.sv
// fabric_reset_sequencer_if: groups the fabric-side reset sequencing signals
interface fabric_reset_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    logic                  FABRIC_RESET_N;
    logic                  SOFT_RST_REQ;
    logic [NUM_STAGES-1:0] STAGE_READY;
    logic [NUM_STAGES-1:0] STAGE_RESET_N;
    logic                  SEQ_DONE;
    logic                  SEQ_ERR;
    logic [2:0]            ERR_STAGE;
    modport master (
        output FABRIC_RESET_N, SOFT_RST_REQ, STAGE_READY,
        input  STAGE_RESET_N, SEQ_DONE, SEQ_ERR, ERR_STAGE
    );
    modport slave (
        input  FABRIC_RESET_N, SOFT_RST_REQ, STAGE_READY,
        output STAGE_RESET_N, SEQ_DONE, SEQ_ERR, ERR_STAGE
    );
endinterface

// File: rtl/fabric_reset_sequencer.sv
// fabric_reset_sequencer: releases fabric reset domains in order, gated by per-stage ready
module fabric_reset_sequencer #(
    parameter int NUM_STAGES      = 4,
    parameter int STAGE_DELAY     = 16,
    parameter int READY_TIMEOUT   = 1024,
    parameter int SOFT_RST_CYCLES = 8
) (
    input logic                     CLK,
    input logic                     RST,
    fabric_reset_sequencer_if.slave bus
);
    localparam int CMAX0 = STAGE_DELAY > READY_TIMEOUT ? STAGE_DELAY : READY_TIMEOUT;
    localparam int CMAX  = CMAX0 > SOFT_RST_CYCLES ? CMAX0 : SOFT_RST_CYCLES;
    localparam int CW    = $clog2(CMAX + 1);
    localparam int TO    = READY_TIMEOUT > 0 ? READY_TIMEOUT : 1;
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_DELAY - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TO - 1);
    localparam logic [CW-1:0] SOFT_LAST = CW'(SOFT_RST_CYCLES - 1);
    localparam logic [2:0] IDX_LAST = 3'(NUM_STAGES - 1);
    localparam logic [2:0] HOLD  = 3'd0;
    localparam logic [2:0] GAP   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] ERROR = 3'd4;
    localparam logic [2:0] SOFT  = 3'd5;
    logic [2:0]            state_q, state_d;
    logic [2:0]            idx_q, idx_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] rel_q, rel_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [2:0]            err_stage_q, err_stage_d;
    logic [NUM_STAGES-1:0] sel;
    logic                  rdy;
    logic                  last;
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_STAGES; i++) sel[i] = 3'(i) == idx_q;
        rdy         = |(bus.STAGE_READY & sel);
        last        = idx_q == IDX_LAST;
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q + CW'(cnt_q != '1);
        rel_d       = rel_q;
        done_d      = done_q;
        err_d       = err_q;
        err_stage_d = err_stage_q;
        if (!bus.FABRIC_RESET_N) begin
            state_d = HOLD;
            idx_d   = '0;
            cnt_d   = '0;
            rel_d   = '0;
            done_d  = 1'b0;
        end else if (bus.SOFT_RST_REQ && (state_q == DONE || state_q == ERROR)) begin
            state_d = SOFT;
            idx_d   = '0;
            cnt_d   = '0;
            rel_d   = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                HOLD: begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
                GAP: if (cnt_q == GAP_LAST) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    rel_d   = rel_q | sel;
                end
                WAIT: if (rdy) begin
                    state_d = last ? DONE : GAP;
                    idx_d   = last ? idx_q : idx_q + 3'd1;
                    done_d  = last;
                    cnt_d   = '0;
                end else if (READY_TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    state_d     = ERROR;
                    err_d       = 1'b1;
                    err_stage_d = idx_q;
                end
                SOFT: if (cnt_q == SOFT_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= HOLD;
            idx_q       <= '0;
            cnt_q       <= '0;
            rel_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_stage_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            rel_q       <= rel_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_stage_q <= err_stage_d;
        end
    end
    assign bus.STAGE_RESET_N = rel_q;
    assign bus.SEQ_DONE      = done_q;
    assign bus.SEQ_ERR       = err_q;
    assign bus.ERR_STAGE     = err_stage_q;
endmodule

// File: tb/tb_fabric_reset_sequencer.sv
// tb_fabric_reset_sequencer: directed scenario tests with hand-derived release timing
module tb_fabric_reset_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    fabric_reset_sequencer_if #(.NUM_STAGES(4)) bus ();
    fabric_reset_sequencer #(
        .NUM_STAGES(4), .STAGE_DELAY(4), .READY_TIMEOUT(32), .SOFT_RST_CYCLES(8)
    ) dut (
        .CLK(clk), .RST(rst), .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    function automatic logic [3:0] exp_rel(input int j, input int first, input int cap);
        int n;
        n = (j < first) ? 0 : (j - first) / 5 + 1;
        if (n > cap) n = cap;
        return 4'((1 << n) - 1);
    endfunction
    task automatic test_reset;
        rst = 1'b1;
        bus.FABRIC_RESET_N = 1'b0;
        bus.SOFT_RST_REQ = 1'b0;
        bus.STAGE_READY = 4'h0;
        for (int j = 0; j < 4; j++) begin
            if (j == 3) rst = 1'b0;
            tick;
            checks++;
            if (bus.STAGE_RESET_N !== 4'b0000) begin errors++; $display("FAIL reset_rel: got %b expected 0000", bus.STAGE_RESET_N); end
            checks++;
            if (bus.SEQ_DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.SEQ_DONE); end
            checks++;
            if (bus.SEQ_ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.SEQ_ERR); end
            checks++;
            if (bus.ERR_STAGE !== 3'd0) begin errors++; $display("FAIL reset_err_stage: got %0d expected 0", bus.ERR_STAGE); end
        end
    endtask
    task automatic test_sequence;
        bus.STAGE_READY = 4'hF;
        bus.FABRIC_RESET_N = 1'b1;
        tick;
        for (int j = 1; j <= 21; j++) begin
            tick;
            checks++;
            if (bus.STAGE_RESET_N !== exp_rel(j, 4, 4)) begin errors++; $display("FAIL seq_rel j=%0d: got %b expected %b", j, bus.STAGE_RESET_N, exp_rel(j, 4, 4)); end
            checks++;
            if (bus.SEQ_DONE !== (j >= 20)) begin errors++; $display("FAIL seq_done j=%0d: got %b expected %b", j, bus.SEQ_DONE, j >= 20); end
        end
    endtask
    task automatic test_fabric_pulse;
        bus.FABRIC_RESET_N = 1'b0;
        tick;
        bus.STAGE_READY = 4'b0001;
        bus.FABRIC_RESET_N = 1'b1;
        tick;
        for (int j = 1; j <= 12; j++) begin
            tick;
            checks++;
            if (bus.STAGE_RESET_N !== exp_rel(j, 4, 2)) begin errors++; $display("FAIL pulse_pre_rel j=%0d: got %b expected %b", j, bus.STAGE_RESET_N, exp_rel(j, 4, 2)); end
        end
        bus.FABRIC_RESET_N = 1'b0;
        tick;
        checks++;
        if (bus.STAGE_RESET_N !== 4'b0000) begin errors++; $display("FAIL pulse_drop_rel: got %b expected 0000", bus.STAGE_RESET_N); end
        bus.FABRIC_RESET_N = 1'b1;
        tick;
        for (int j = 1; j <= 5; j++) begin
            tick;
            checks++;
            if (bus.STAGE_RESET_N !== exp_rel(j, 4, 1)) begin errors++; $display("FAIL pulse_rerel j=%0d: got %b expected %b", j, bus.STAGE_RESET_N, exp_rel(j, 4, 1)); end
        end
    endtask
    task automatic test_timeout(input bit prior_err);
        bus.FABRIC_RESET_N = 1'b0;
        tick;
        bus.STAGE_READY = 4'b1011;
        bus.FABRIC_RESET_N = 1'b1;
        tick;
        for (int j = 1; j <= 50; j++) begin
            tick;
            checks++;
            if (bus.STAGE_RESET_N !== exp_rel(j, 4, 3)) begin errors++; $display("FAIL to_rel j=%0d: got %b expected %b", j, bus.STAGE_RESET_N, exp_rel(j, 4, 3)); end
            checks++;
            if (bus.SEQ_ERR !== (prior_err || j >= 46)) begin errors++; $display("FAIL to_err j=%0d: got %b expected %b", j, bus.SEQ_ERR, prior_err || j >= 46); end
            checks++;
            if (bus.SEQ_DONE !== 1'b0) begin errors++; $display("FAIL to_done j=%0d: got %b expected 0", j, bus.SEQ_DONE); end
            if (j >= 46) begin
                checks++;
                if (bus.ERR_STAGE !== 3'd2) begin errors++; $display("FAIL to_err_stage j=%0d: got %0d expected 2", j, bus.ERR_STAGE); end
            end
        end
    endtask
    task automatic test_err_kept;
        bus.FABRIC_RESET_N = 1'b0;
        tick;
        checks++;
        if (bus.SEQ_ERR !== 1'b1) begin errors++; $display("FAIL kept_err: got %b expected 1", bus.SEQ_ERR); end
        checks++;
        if (bus.ERR_STAGE !== 3'd2) begin errors++; $display("FAIL kept_err_stage: got %0d expected 2", bus.ERR_STAGE); end
        checks++;
        if (bus.STAGE_RESET_N !== 4'b0000) begin errors++; $display("FAIL kept_rel: got %b expected 0000", bus.STAGE_RESET_N); end
    endtask
    task automatic test_soft(input string tag, input logic [3:0] ready_after);
        bus.SOFT_RST_REQ = 1'b1;
        tick;
        bus.SOFT_RST_REQ = 1'b0;
        bus.STAGE_READY = ready_after;
        checks++;
        if (bus.STAGE_RESET_N !== 4'b0000) begin errors++; $display("FAIL %s_entry_rel: got %b expected 0000", tag, bus.STAGE_RESET_N); end
        checks++;
        if (bus.SEQ_ERR !== 1'b0) begin errors++; $display("FAIL %s_entry_err: got %b expected 0", tag, bus.SEQ_ERR); end
        checks++;
        if (bus.SEQ_DONE !== 1'b0) begin errors++; $display("FAIL %s_entry_done: got %b expected 0", tag, bus.SEQ_DONE); end
        for (int j = 1; j <= 29; j++) begin
            bus.SOFT_RST_REQ = (j == 3 || j == 10);
            tick;
            bus.SOFT_RST_REQ = 1'b0;
            checks++;
            if (bus.STAGE_RESET_N !== exp_rel(j, 12, 4)) begin errors++; $display("FAIL %s_rel j=%0d: got %b expected %b", tag, j, bus.STAGE_RESET_N, exp_rel(j, 12, 4)); end
            checks++;
            if (bus.SEQ_DONE !== (j >= 28)) begin errors++; $display("FAIL %s_done j=%0d: got %b expected %b", tag, j, bus.SEQ_DONE, j >= 28); end
            checks++;
            if (bus.SEQ_ERR !== 1'b0) begin errors++; $display("FAIL %s_err j=%0d: got %b expected 0", tag, j, bus.SEQ_ERR); end
        end
    endtask
    initial begin
        test_reset;
        test_sequence;
        test_fabric_pulse;
        test_timeout(1'b0);
        test_err_kept;
        test_timeout(1'b1);
        test_soft("soft_err", 4'hF);
        test_soft("soft_done", 4'hF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
